uart_rx_capture: RTL
====================

Name: uart_rx_capture

Overview:
- Synthesizable UART receiver that consumes the serial TX line driven out of the SoC pad ring (the io_pad1 UART TX path), for example on FPGA bring-up boards and in the SoC bench.
- Deserializes 8N1 frames and buffers the bytes in a first-word-fall-through FIFO.
- Presents the bytes on a valid/ready stream for a host-side logger or a self-checking scoreboard.
- Flags framing errors and FIFO overflow.

Parameters:
- CLK_FREQ, 25000000, input clock frequency in Hz.
- BAUD, 115200, line rate in baud.
- FIFO_DEPTH, 16, byte entries; power of two, minimum 2.
- Derived value DIV = CLK_FREQ/BAUD, integer truncation; 217 at the defaults.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- rx_i  in  1  serial line, idle high, asynchronous to clk_i
- clr_i  in  1  synchronous clear of the sticky flags
- data_o  out  8  head-of-FIFO byte
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer accepts data_o when valid_o=1
- frame_err_o  out  1  one-cycle pulse on a bad stop bit
- overflow_o  out  1  sticky: a byte was dropped because the FIFO was full
- count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, asynchronous and active-high:
  - FSM goes to IDLE.
  - Synchronizer flops go to 1.
  - FIFO pointers go to 0.
  - Outputs: data_o=0, valid_o=0, frame_err_o=0, overflow_o=0, count_o=0.
- Reset asserted mid-frame discards the partial byte. After reset releases, a frame is not recognised until rx_i has been seen high and then falls.
- rx_i passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. A bit counter and a baud counter (0..DIV-1) drive it.
  - IDLE: falling edge of rxs loads the baud counter with DIV/2 and moves to START.
  - START: when the baud counter expires, sample rxs.
    - rxs=0: move to DATA, counter reloads DIV.
    - rxs=1: glitch; return to IDLE with no output.
  - DATA: sample every DIV cycles, 8 samples, LSB first, shifting into the shift register.
  - STOP: sample after DIV cycles.
    - rxs=1: push the byte and return to IDLE.
    - rxs=0: pulse frame_err_o for exactly 1 cycle, drop the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1 (covers break conditions), then go to IDLE.
- Sampling point is the bit centre ±1 clk. Total frame decode is 9.5*DIV cycles after the start edge, plus 2 cycles of synchronizer latency.
- FIFO:
  - First-word fall-through. A byte pushed in cycle N appears on data_o with valid_o=1 in cycle N+1.
  - A pop happens when valid_o && ready_i.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Simultaneous push and pop when full leaves count unchanged and loses no data.
  - A push that is not accepted sets overflow_o, and the byte is discarded.
  - A pop when empty cannot occur, because valid_o=0.
  - Pointers wrap modulo FIFO_DEPTH. count_o reflects pushes and pops in the cycle after they happen.
  - data_o is stable while valid_o=1 and ready_i=0.
- clr_i clears overflow_o on the next edge.
  - If clr_i coincides with a new overflow, the set wins.
  - clr_i does not flush the FIFO.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP and samples one extra bit.
  - Even parity is required.
  - On a mismatch, frame_err_o pulses, the byte is dropped, and the FSM goes to WAIT_IDLE if the stop bit is also low, otherwise to IDLE.
  - Frame decode becomes 10.5*DIV cycles.
- When undefined: pure 8N1 with no parity logic.

Test Plan:
- Drive 0x55, then 0xA3, at DIV=217 with ready_i=1 -> two valid_o beats with data_o=0x55 and then 0xA3. frame_err_o and overflow_o stay 0.
- Drive 0x3C with the stop bit held low for 1.5 bit periods -> one frame_err_o pulse, no push, count_o=0. A following 0x7E is received correctly.
- Drive a 50-cycle low glitch on rx_i -> no push, no error, FSM back in IDLE.
- With ready_i=0, send 17 bytes 0x00..0x10 -> count_o=16 and overflow_o=1. Then, with ready_i=1, the bytes drain 0x00..0x0F in order. Pulsing clr_i clears overflow_o.
- Assert rst_i during bit 4 of 0xF0, release it, then send 0x81 -> only 0x81 is received.
- With UART_RX_PARITY_EN defined, send 0x07 with parity=1 -> accepted. Send 0x07 with parity=0 -> frame_err_o pulse and no push.

Source files
------------

// File: rtl/uart_rx_capture.sv
// UART 8N1 receiver with a first-word-fall-through byte FIFO and a valid/ready output stream.
// Optional even-parity framing when UART_RX_PARITY_EN is defined.
module uart_rx_capture #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    input  logic                          clr_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int CW   = $clog2(DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [1:0]      r_vld;
    logic            r_armed;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bitCnt;
    logic [7:0]      r_shift;
    logic            r_push;
    logic [7:0]      r_pushData;
    logic            r_frameErr;
`ifdef UART_RX_PARITY_EN
    logic            r_parity;
`endif

    logic            w_rxs;
    logic            w_tick;
    logic            w_parOk;

    assign w_rxs  = r_sync2;
    assign w_tick = (r_baud == '0);
`ifdef UART_RX_PARITY_EN
    assign w_parOk = ~^{r_shift, r_parity};
`else
    assign w_parOk = 1'b1;
`endif

    // r_vld marks when r_sync2 holds a real line sample, so a start edge is only
    // accepted after the line has genuinely been observed high since reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_vld      <= 2'b00;
            r_armed    <= 1'b0;
            r_baud     <= '0;
            r_bitCnt   <= 3'd0;
            r_shift    <= 8'h00;
            r_push     <= 1'b0;
            r_pushData <= 8'h00;
            r_frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_sync1    <= rx_i;
            r_sync2    <= r_sync1;
            r_vld      <= {r_vld[0], 1'b1};
            r_push     <= 1'b0;
            r_frameErr <= 1'b0;
            if (!w_tick) begin
                r_baud <= r_baud - 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (r_armed && !w_rxs) begin
                        r_state <= START;
                        r_baud  <= CW'(DIV / 2);
                        r_armed <= 1'b0;
                    end else if (r_vld[1] && w_rxs) begin
                        r_armed <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (!w_rxs) begin
                            r_state  <= DATA;
                            r_baud   <= CW'(DIV - 1);
                            r_bitCnt <= 3'd0;
                        end else begin
                            r_state <= IDLE;
                            r_armed <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift  <= {w_rxs, r_shift[7:1]};
                        r_baud   <= CW'(DIV - 1);
                        r_bitCnt <= r_bitCnt + 1'b1;
                        if (r_bitCnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_parity <= w_rxs;
                        r_baud   <= CW'(DIV - 1);
                        r_state  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        if (w_rxs && w_parOk) begin
                            r_push     <= 1'b1;
                            r_pushData <= r_shift;
                            r_state    <= IDLE;
                            r_armed    <= 1'b1;
                        end else begin
                            r_frameErr <= 1'b1;
                            if (w_rxs) begin
                                r_state <= IDLE;
                                r_armed <= 1'b1;
                            end else begin
                                r_state <= WAIT_IDLE;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (w_rxs) begin
                        r_state <= IDLE;
                        r_armed <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [CNTW-1:0] r_count;
    logic            r_overflow;

    logic            w_pop;
    logic            w_accept;

    assign w_pop    = valid_o && ready_i;
    assign w_accept = r_push && ((r_count < CNTW'(FIFO_DEPTH)) || w_pop);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (r_push && !w_accept) begin
                r_overflow <= 1'b1;
            end else if (clr_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mem[r_wrPtr] <= r_pushData;
        end
    end

    assign valid_o     = (r_count != '0);
    assign data_o      = valid_o ? r_mem[r_rdPtr] : 8'h00;
    assign count_o     = r_count;
    assign frame_err_o = r_frameErr;
    assign overflow_o  = r_overflow;

endmodule
